// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the SoC reset sequencer.
// Holds the sequencer state encoding, the reset-cause codes and a
// constant clog2 used to size index and watchdog counters.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_TRIG = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop synchroniser for an asynchronous level input.
// The async active-high clear forces both stages low so a stale request
// cannot leak out of a reset.
module reset_sync (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset generator: holds NCHAN reset domains after power-on or a
// reset request, then releases them one by one in index order, STAGGER
// cycles apart, after an initial HOLD_CYCLES hold.
// Optional feature macro: RESET_SEQ_WDT_EN adds the wdt_kick port and a
// watchdog that re-enters HOLD if the system stops kicking it in RUN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int               NCHAN       = 4,
  parameter int               CW          = 20,
  parameter int               HOLD_CYCLES = 20'hFFFFF,
  parameter int               STAGGER     = 128,
  parameter logic [NCHAN-1:0] POL_MASK    = '0,
  parameter int               WDT_CYCLES  = 2**24
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             trigger_reset,
`ifdef RESET_SEQ_WDT_EN
  input  logic             wdt_kick,
`endif
  output logic [NCHAN-1:0] rst_out,
  output logic             seq_done,
  output logic [1:0]       rst_cause
);

  localparam int               IW        = (NCHAN > 1) ? clog2(NCHAN) : 1;
  localparam logic [CW-1:0]    HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]    STAG_LOAD = CW'(STAGGER - 1);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(NCHAN - 1);
  localparam logic [NCHAN-1:0] ALL_ACT   = '1;

  // Elaboration-time guard against parameter values the counters cannot express.
  if (NCHAN < 1 || HOLD_CYCLES < 1 || STAGGER < 1 || WDT_CYCLES < 2 ||
      HOLD_CYCLES >= (2**CW) || STAGGER >= (2**CW)) begin : g_param_check
    $error("reset_sequencer: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NCHAN-1:0] act_q, act_d;
  logic [NCHAN-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;
  logic             trig_s;
  logic             wdt_fire;

  reset_sync u_trig_sync (
    .clk (sys_clk),
    .clr (sys_rst),
    .d   (trigger_reset),
    .q   (trig_s)
  );

`ifdef RESET_SEQ_WDT_EN
  localparam int            WW       = (WDT_CYCLES > 2) ? clog2(WDT_CYCLES) : 1;
  localparam logic [WW-1:0] WDT_LOAD = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_q, wdt_d;

  // Watchdog reloads outside RUN or on a kick, otherwise counts down.
  always_comb begin
    wdt_fire = (state_q == RUN) && !wdt_kick && (wdt_q == '0);
    if ((state_q != RUN) || wdt_kick) begin
      wdt_d = WDT_LOAD;
    end else begin
      wdt_d = wdt_q - 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wdt_q <= WDT_LOAD;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign wdt_fire = 1'b0;
`endif

  // Next-state logic: trigger beats watchdog, both beat normal sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    act_d   = act_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (trig_s) begin
      state_d = HOLD;
      cnt_d   = HOLD_LOAD;
      act_d   = ALL_ACT;
      done_d  = 1'b0;
      cause_d = CAUSE_TRIG;
    end else if (wdt_fire) begin
      state_d = HOLD;
      cnt_d   = HOLD_LOAD;
      act_d   = ALL_ACT;
      done_d  = 1'b0;
      cause_d = CAUSE_WDT;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == '0) begin
            act_d[0] = 1'b0;
            if (NCHAN == 1) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
              idx_d   = IW'(1);
              cnt_d   = STAG_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == '0) begin
            act_d[idx_q] = 1'b0;
            if (idx_q == LAST_IDX) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
              cnt_d = STAG_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          act_d   = ALL_ACT;
          done_d  = 1'b0;
        end
      endcase
    end
    out_d = act_d ^ POL_MASK;
  end

  // Sequencer registers; outputs come straight from flops so they are glitch-free.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= HOLD;
      cnt_q   <= HOLD_LOAD;
      idx_q   <= '0;
      act_q   <= ALL_ACT;
      out_q   <= ALL_ACT ^ POL_MASK;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      out_q   <= out_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign rst_out   = out_q;
  assign seq_done  = done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (NCHAN=4, HOLD=16, STAGGER=4,
// POL_MASK=0101). Build with RESET_SEQ_WDT_EN defined to exercise the
// watchdog as well.
module tb_reset_sequencer;

  localparam int         NCH  = 4;
  localparam int         HOLD = 16;
  localparam int         STAG = 4;
  localparam int         WDT  = 32;
  localparam logic [3:0] MASK = 4'b0101;

  logic       sys_clk;
  logic       sys_rst;
  logic       trigger_reset;
`ifdef RESET_SEQ_WDT_EN
  logic       wdt_kick;
`endif
  logic [3:0] rst_out;
  logic       seq_done;
  logic [1:0] rst_cause;

  int errors = 0;
  int checks = 0;

  // Reference model: time is counted in edges since the last reset; L is
  // the edge at which the most recent HOLD entry happened (0 = reset).
  int         n;
  int         last_load;
  logic [1:0] m_cause;
  int         wdt_ref;
  bit         h1, h2, eff, run_before;

  reset_sequencer #(
    .NCHAN       (NCH),
    .CW          (8),
    .HOLD_CYCLES (HOLD),
    .STAGGER     (STAG),
    .POL_MASK    (MASK),
    .WDT_CYCLES  (WDT)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .trigger_reset (trigger_reset),
`ifdef RESET_SEQ_WDT_EN
    .wdt_kick      (wdt_kick),
`endif
    .rst_out       (rst_out),
    .seq_done      (seq_done),
    .rst_cause     (rst_cause)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [3:0] exp_act();
    logic [3:0] a;
    for (int i = 0; i < NCH; i++) a[i] = (n < last_load + HOLD + i * STAG);
    return a;
  endfunction

  function automatic logic exp_done();
    return n >= last_load + HOLD + (NCH - 1) * STAG;
  endfunction

  function automatic logic [3:0] exp_rst();
    return exp_act() ^ MASK;
  endfunction

  // Advance the model once per clock edge.
  always @(posedge sys_clk) begin
    if (sys_rst) begin
      n = 0; last_load = 0; m_cause = 2'b00; h1 = 0; h2 = 0; wdt_ref = 0;
    end else begin
      n = n + 1;
      run_before = (n - 1) >= last_load + HOLD + (NCH - 1) * STAG;
      eff = h2; h2 = h1; h1 = trigger_reset;
      if (eff) begin
        last_load = n; m_cause = 2'b01;
      end
`ifdef RESET_SEQ_WDT_EN
      else if (run_before && !wdt_kick && n == wdt_ref + WDT) begin
        last_load = n; m_cause = 2'b10;
      end
      if (!run_before || wdt_kick) wdt_ref = n;
`endif
    end
  end

  task automatic test_reset();
    sys_rst = 1'b1; trigger_reset = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (rst_out !== 4'b1010 || seq_done !== 1'b0 || rst_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_state rst_out=%b done=%b cause=%b expected 1010/0/00", rst_out, seq_done, rst_cause);
    end
    $display("reset_state rst_out=%b done=%b cause=%b", rst_out, seq_done, rst_cause);
  endtask

  task automatic test_power_on();
    sys_rst = 1'b0;
    for (int c = 0; c < 34; c++) begin
      @(negedge sys_clk);
      checks++;
      if (rst_out !== exp_rst() || seq_done !== exp_done() || rst_cause !== m_cause) begin
        errors++;
        $display("FAIL power_on edge=%0d rst_out=%b want %b done=%b want %b cause=%b want %b",
                 n, rst_out, exp_rst(), seq_done, exp_done(), rst_cause, m_cause);
      end
      if (n == 15 || n == 16 || n == 28) begin
        logic [3:0] want;
        want = (n == 15) ? 4'b1010 : (n == 16) ? 4'b1011 : 4'b0101;
        checks++;
        if (rst_out !== want || seq_done !== (n == 28)) begin
          errors++;
          $display("FAIL power_on_edge%0d rst_out=%b done=%b want %b/%b", n, rst_out, seq_done, want, n == 28);
        end
        $display("power_on edge=%0d rst_out=%b done=%b", n, rst_out, seq_done);
      end
    end
  endtask

  task automatic test_trigger_pulse();
    @(negedge sys_clk);
    trigger_reset = 1'b1;
    @(negedge sys_clk);
    trigger_reset = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (rst_out !== 4'b1010 || seq_done !== 1'b0 || rst_cause !== 2'b01) begin
      errors++;
      $display("FAIL trig_pulse_assert rst_out=%b done=%b cause=%b want 1010/0/01", rst_out, seq_done, rst_cause);
    end
    $display("trig_pulse assert rst_out=%b cause=%b", rst_out, rst_cause);
    for (int c = 0; c < 32; c++) begin
      @(negedge sys_clk);
      checks++;
      if (rst_out !== exp_rst() || seq_done !== exp_done() || rst_cause !== m_cause) begin
        errors++;
        $display("FAIL trig_pulse edge=%0d rst_out=%b want %b done=%b want %b cause=%b want %b",
                 n, rst_out, exp_rst(), seq_done, exp_done(), rst_cause, m_cause);
      end
    end
    $display("trig_pulse rerelease rst_out=%b done=%b", rst_out, seq_done);
  endtask

  task automatic test_trigger_held();
    bit found = 0;
    @(negedge sys_clk);
    trigger_reset = 1'b1;
    @(negedge sys_clk);
    trigger_reset = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge sys_clk);
      checks++;
      if (rst_out !== exp_rst() || seq_done !== exp_done()) begin
        errors++;
        $display("FAIL trig_held_pre edge=%0d rst_out=%b want %b", n, rst_out, exp_rst());
      end
      if (n - last_load == HOLD + STAG + 1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL trig_held_wait timed out: got no mid-release window, required one");
    end
    trigger_reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      if (c == 2) begin
        checks++;
        if (rst_out !== 4'b1010) begin
          errors++;
          $display("FAIL trig_held_reassert rst_out=%b want 1010", rst_out);
        end
      end
      checks++;
      if (rst_out !== exp_rst() || seq_done !== exp_done() || rst_cause !== m_cause) begin
        errors++;
        $display("FAIL trig_held edge=%0d rst_out=%b want %b cause=%b want %b", n, rst_out, exp_rst(), rst_cause, m_cause);
      end
    end
    trigger_reset = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(negedge sys_clk);
      checks++;
      if (rst_out !== exp_rst() || seq_done !== exp_done() || rst_cause !== m_cause) begin
        errors++;
        $display("FAIL trig_held_post edge=%0d rst_out=%b want %b done=%b want %b", n, rst_out, exp_rst(), seq_done, exp_done());
      end
    end
    $display("trig_held done rst_out=%b seq_done=%b cause=%b", rst_out, seq_done, rst_cause);
  endtask

  task automatic test_async_reset();
    @(negedge sys_clk);
    #1 sys_rst = 1'b1;
    #1;
    checks++;
    if (rst_out !== 4'b1010 || seq_done !== 1'b0 || rst_cause !== 2'b00) begin
      errors++;
      $display("FAIL async_reset rst_out=%b done=%b cause=%b want 1010/0/00", rst_out, seq_done, rst_cause);
    end
    $display("async_reset immediate rst_out=%b done=%b", rst_out, seq_done);
    n = 0; last_load = 0; m_cause = 2'b00; h1 = 0; h2 = 0; wdt_ref = 0;
    #1 sys_rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge sys_clk);
      checks++;
      if (rst_out !== exp_rst() || seq_done !== exp_done() || rst_cause !== m_cause) begin
        errors++;
        $display("FAIL async_seq edge=%0d rst_out=%b want %b done=%b want %b", n, rst_out, exp_rst(), seq_done, exp_done());
      end
    end
  endtask

  task automatic test_random();
    int trig_len = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge sys_clk);
      checks++;
      if (rst_out !== exp_rst() || seq_done !== exp_done() || rst_cause !== m_cause) begin
        errors++;
        $display("FAIL random edge=%0d rst_out=%b want %b done=%b want %b cause=%b want %b",
                 n, rst_out, exp_rst(), seq_done, exp_done(), rst_cause, m_cause);
      end
      if (trig_len > 0) begin
        trigger_reset = 1'b1; trig_len--;
      end else begin
        trigger_reset = 1'b0;
        if ($urandom_range(0, 39) == 0) trig_len = $urandom_range(1, 4);
      end
`ifdef RESET_SEQ_WDT_EN
      wdt_kick = ($urandom_range(0, 24) == 0);
`endif
    end
    trigger_reset = 1'b0;
`ifdef RESET_SEQ_WDT_EN
    wdt_kick = 1'b0;
`endif
    $display("random done edge=%0d rst_out=%b cause=%b", n, rst_out, rst_cause);
  endtask

`ifdef RESET_SEQ_WDT_EN
  task automatic test_watchdog();
    int  run_edge;
    bit  fired = 0;
    for (int c = 0; c < 60 && !exp_done(); c++) @(negedge sys_clk);
    checks++;
    if (!exp_done()) begin
      errors++;
      $display("FAIL wdt_wait_run timed out: model never reached run");
    end
    run_edge = last_load + HOLD + (NCH - 1) * STAG;
    for (int c = 0; c < 45; c++) begin
      @(negedge sys_clk);
      checks++;
      if (rst_out !== exp_rst() || seq_done !== exp_done() || rst_cause !== m_cause) begin
        errors++;
        $display("FAIL wdt_nokick edge=%0d rst_out=%b want %b cause=%b want %b", n, rst_out, exp_rst(), rst_cause, m_cause);
      end
      if (n == run_edge + 32) begin
        fired = 1;
        checks++;
        if (rst_out !== 4'b1010 || rst_cause !== 2'b10 || seq_done !== 1'b0) begin
          errors++;
          $display("FAIL wdt_timeout rst_out=%b cause=%b done=%b want 1010/10/0", rst_out, rst_cause, seq_done);
        end
        $display("wdt_timeout edge=%0d rst_out=%b cause=%b", n, rst_out, rst_cause);
      end
    end
    checks++;
    if (!fired) begin
      errors++;
      $display("FAIL wdt_timeout_seen got none, required one at edge %0d", run_edge + 32);
    end
    for (int c = 0; c < 60 && !exp_done(); c++) @(negedge sys_clk);
    for (int c = 0; c < 1000; c++) begin
      wdt_kick = (c % 20 == 0);
      @(negedge sys_clk);
      checks++;
      if (rst_out !== 4'b0101 || seq_done !== 1'b1 || rst_out !== exp_rst()) begin
        errors++;
        $display("FAIL wdt_kicked edge=%0d rst_out=%b done=%b want 0101/1", n, rst_out, seq_done);
      end
    end
    wdt_kick = 1'b0;
    $display("wdt_kicked 1000 cycles rst_out=%b done=%b", rst_out, seq_done);
  endtask
`endif

  initial begin
`ifdef RESET_SEQ_WDT_EN
    wdt_kick = 1'b0;
`endif
    test_reset();
    test_power_on();
    test_trigger_pulse();
    test_trigger_held();
    test_async_reset();
`ifdef RESET_SEQ_WDT_EN
    test_watchdog();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
